// File: rtl/alarm_sequencer_if.sv
// alarm_sequencer_if: groups the alarm sequencer's request/sensor/command
// inputs and its actuator/LCD/status outputs.
//   master : drives arm, disarm, trips, WIFI command, lock_ack; observes outputs
//   slave  : the sequencer side (consumes requests, drives outputs)
interface alarm_sequencer_if;
  logic       arm;
  logic       disarm;
  logic       trip_else;
  logic       trip_hub;
  logic       cmd_valid;
  logic [3:0] cmd;
  logic       lock_ack;

  logic       siren;
  logic       lock_req;
  logic       lock_fault;
  logic       notify;
  logic [1:0] msg;
  logic [2:0] state_o;
  logic [7:0] countdown;

  modport master (
    output arm, disarm, trip_else, trip_hub, cmd_valid, cmd, lock_ack,
    input  siren, lock_req, lock_fault, notify, msg, state_o, countdown
  );

  modport slave (
    input  arm, disarm, trip_else, trip_hub, cmd_valid, cmd, lock_ack,
    output siren, lock_req, lock_fault, notify, msg, state_o, countdown
  );
endinterface

// File: rtl/alarm_sequencer.sv
// alarm_sequencer: timed alarm-response state machine (exit delay, entry
// delay, siren time limit, servo lock handshake with timeout).
//   clk    : system clock, posedge
//   reset  : synchronous, active-low
//   bus    : slave side of alarm_sequencer_if
//            in : arm, disarm, trip_else, trip_hub, cmd_valid, cmd[3:0], lock_ack
//            out: siren, lock_req, lock_fault, notify, msg[1:0],
//                 state_o[2:0], countdown[7:0]
module alarm_sequencer #(
  parameter int unsigned TICK_CYCLES = 50_000_000,
  parameter int unsigned EXIT_S      = 30,
  parameter int unsigned ENTRY_S     = 15,
  parameter int unsigned SIREN_S     = 180,
  parameter int unsigned LOCK_TO_S   = 2
) (
  input  logic              clk,
  input  logic              reset,
  alarm_sequencer_if.slave  bus
);

  localparam int unsigned PRESC_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned ST_W    = 3;

  localparam logic [3:0] CMD_DISARM   = 4'b1010;
  localparam logic [3:0] CMD_REARM    = 4'b1011;
  localparam logic [3:0] CMD_ESCALATE = 4'b1100;

  typedef enum logic [ST_W-1:0] {
    IDLE  = 3'd0,
    EXIT  = 3'd1,
    ARMED = 3'd2,
    ENTRY = 3'd3,
    ALARM = 3'd4,
    EMERG = 3'd5
  } state_e;

  state_e             state_q,      state_d;
  logic [PRESC_W-1:0] presc_q,      presc_d;
  logic [CNT_W-1:0]   countdown_q,  countdown_d;
  logic [CNT_W-1:0]   lock_cnt_q,   lock_cnt_d;
  logic               lock_acked_q, lock_acked_d;
  logic               lock_fault_q, lock_fault_d;
  logic               siren_q,      siren_d;
  logic               lock_req_q,   lock_req_d;
  logic               notify_q,     notify_d;
  logic [1:0]         msg_q,        msg_d;

  logic tick;
  logic expire;
  logic disarm_req;
  logic rearm_cmd;
  logic escalate_cmd;
  logic state_chg;

  // Request decode and tick/expiry qualification
  always_comb begin
    tick         = (presc_q == PRESC_W'(TICK_CYCLES - 1));
    expire       = tick && (countdown_q == CNT_W'(1));
    disarm_req   = bus.disarm || (bus.cmd_valid && (bus.cmd == CMD_DISARM));
    rearm_cmd    = bus.cmd_valid && (bus.cmd == CMD_REARM);
    escalate_cmd = bus.cmd_valid && (bus.cmd == CMD_ESCALATE);
  end

  // Next-state: disarm overrides everything; requests are checked before expiry
  always_comb begin
    state_d = state_q;
    if (disarm_req) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:  if (bus.arm) state_d = EXIT;
        EXIT:  if (expire) state_d = ARMED;
        ARMED: begin
          if (bus.trip_hub)       state_d = EMERG;
          else if (bus.trip_else) state_d = ENTRY;
        end
        ENTRY: begin
          if (bus.trip_hub) state_d = EMERG;
          else if (expire)  state_d = ALARM;
        end
        ALARM: begin
          if (rearm_cmd)         state_d = EXIT;
          else if (escalate_cmd) state_d = EMERG;
        end
        EMERG: if (rearm_cmd) state_d = EXIT;
        default: state_d = IDLE;
      endcase
    end
  end

  // Prescaler and phase countdown; both restart on any state change
  always_comb begin
    state_chg   = (state_d != state_q);
    presc_d     = presc_q + PRESC_W'(1);
    countdown_d = countdown_q;

    if (state_chg || tick) presc_d = '0;

    if (state_chg) begin
      case (state_d)
        EXIT:         countdown_d = CNT_W'(EXIT_S);
        ENTRY:        countdown_d = CNT_W'(ENTRY_S);
        ALARM, EMERG: countdown_d = CNT_W'(SIREN_S);
        default:      countdown_d = '0;
      endcase
    end else if (tick && (countdown_q != '0)) begin
      countdown_d = countdown_q - CNT_W'(1);
    end
  end

  // Lock handshake: timeout counter runs only while waiting for lock_ack in EMERG
  always_comb begin
    lock_cnt_d   = lock_cnt_q;
    lock_acked_d = lock_acked_q;
    lock_fault_d = lock_fault_q;

    if (state_chg && (state_d == EMERG)) begin
      lock_cnt_d   = CNT_W'(LOCK_TO_S);
      lock_acked_d = 1'b0;
    end else if ((state_q == EMERG) && (state_d == EMERG) && !lock_acked_q) begin
      if (bus.lock_ack) begin
        lock_acked_d = 1'b1;
      end else if (tick && (lock_cnt_q != '0)) begin
        lock_cnt_d = lock_cnt_q - CNT_W'(1);
        if (lock_cnt_q == CNT_W'(1)) lock_fault_d = 1'b1;
      end
    end

    // Sticky fault is only cleared by returning to IDLE
    if (state_d == IDLE) lock_fault_d = 1'b0;
  end

  // Output decode from the next state so outputs align with state_o
  always_comb begin
    siren_d    = ((state_d == ALARM) || (state_d == EMERG)) && (countdown_d != '0);
    lock_req_d = (state_d == EMERG);
    notify_d   = state_chg && ((state_d == ALARM) || (state_d == EMERG));
    case (state_d)
      EXIT, ARMED, ENTRY: msg_d = 2'b01;
      ALARM:              msg_d = 2'b10;
      EMERG:              msg_d = 2'b11;
      default:            msg_d = 2'b00;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      presc_q      <= '0;
      countdown_q  <= '0;
      lock_cnt_q   <= '0;
      lock_acked_q <= 1'b0;
      lock_fault_q <= 1'b0;
      siren_q      <= 1'b0;
      lock_req_q   <= 1'b0;
      notify_q     <= 1'b0;
      msg_q        <= 2'b00;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      countdown_q  <= countdown_d;
      lock_cnt_q   <= lock_cnt_d;
      lock_acked_q <= lock_acked_d;
      lock_fault_q <= lock_fault_d;
      siren_q      <= siren_d;
      lock_req_q   <= lock_req_d;
      notify_q     <= notify_d;
      msg_q        <= msg_d;
    end
  end

  assign bus.siren      = siren_q;
  assign bus.lock_req   = lock_req_q;
  assign bus.lock_fault = lock_fault_q;
  assign bus.notify     = notify_q;
  assign bus.msg        = msg_q;
  assign bus.state_o    = state_q;
  assign bus.countdown  = countdown_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// tb_alarm_sequencer: scoreboard bench for alarm_sequencer with short timers.
module tb_alarm_sequencer;

  localparam int unsigned TB_TICK  = 10;
  localparam int unsigned TB_EXIT  = 3;
  localparam int unsigned TB_ENTRY = 2;
  localparam int unsigned TB_SIREN = 4;
  localparam int unsigned TB_LOCK  = 2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_EXIT  = 3'd1;
  localparam logic [2:0] S_ARMED = 3'd2;
  localparam logic [2:0] S_ENTRY = 3'd3;
  localparam logic [2:0] S_ALARM = 3'd4;
  localparam logic [2:0] S_EMERG = 3'd5;

  typedef struct packed {
    logic [2:0] st;
    logic [7:0] cd;
    logic       siren;
    logic       lreq;
    logic       lflt;
    logic       ntf;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  exp_t  exp_q[$];
  string tag_q[$];

  alarm_sequencer_if bif ();

  alarm_sequencer #(
    .TICK_CYCLES (TB_TICK),
    .EXIT_S      (TB_EXIT),
    .ENTRY_S     (TB_ENTRY),
    .SIREN_S     (TB_SIREN),
    .LOCK_TO_S   (TB_LOCK)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [1:0] msg_of(input logic [2:0] st);
    case (st)
      S_EXIT, S_ARMED, S_ENTRY: return 2'b01;
      S_ALARM:                  return 2'b10;
      S_EMERG:                  return 2'b11;
      default:                  return 2'b00;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Push the expectation for the coming edge, then pop and compare after it
  task automatic step(input string tag, input logic [2:0] st, input logic [7:0] cd,
                      input logic siren, input logic lreq, input logic lflt, input logic ntf);
    exp_t  e;
    string t;
    e.st = st; e.cd = cd; e.siren = siren; e.lreq = lreq; e.lflt = lflt; e.ntf = ntf;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check_eq({t, ".state"},      32'(bif.state_o),    32'(e.st));
    check_eq({t, ".countdown"},  32'(bif.countdown),  32'(e.cd));
    check_eq({t, ".siren"},      32'(bif.siren),      32'(e.siren));
    check_eq({t, ".lock_req"},   32'(bif.lock_req),   32'(e.lreq));
    check_eq({t, ".lock_fault"}, 32'(bif.lock_fault), 32'(e.lflt));
    check_eq({t, ".notify"},     32'(bif.notify),     32'(e.ntf));
    check_eq({t, ".msg"},        32'(bif.msg),        32'(msg_of(e.st)));
  endtask

  // Cycles k0..k1 after entering a timed phase loaded with 'load'
  task automatic timed(input string tag, input logic [2:0] st, input int load,
                       input int k0, input int k1, input logic lreq, input logic lflt);
    for (int k = k0; k <= k1; k++) begin
      int cd;
      cd = load - (k / int'(TB_TICK));
      if (cd < 0) cd = 0;
      step(tag, st, 8'(cd), ((st == S_ALARM) || (st == S_EMERG)) && (cd != 0),
           lreq, lflt, 1'b0);
    end
  endtask

  task automatic clear_inputs();
    bif.arm = 1'b0; bif.disarm = 1'b0; bif.trip_else = 1'b0; bif.trip_hub = 1'b0;
    bif.cmd_valid = 1'b0; bif.cmd = 4'b0000; bif.lock_ack = 1'b0;
  endtask

  task automatic go_armed(input string tag);
    bif.arm = 1'b1;
    step({tag, ".arm"}, S_EXIT, 8'(TB_EXIT), 1'b0, 1'b0, 1'b0, 1'b0);
    bif.arm = 1'b0;
    timed({tag, ".exit"}, S_EXIT, TB_EXIT, 1, 29, 1'b0, 1'b0);
    step({tag, ".armed"}, S_ARMED, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    clear_inputs();
    reset = 1'b0;
    bif.arm = 1'b1;
    step("rst0", S_IDLE, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("rst1", S_IDLE, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    bif.arm = 1'b0;
    step("idle", S_IDLE, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Arm, exit delay with ignored sensors and arm, then ARMED at 30 cycles
    bif.arm = 1'b1;
    step("arm", S_EXIT, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    bif.arm = 1'b0;
    timed("exit", S_EXIT, TB_EXIT, 1, 4, 1'b0, 1'b0);
    bif.trip_hub = 1'b1; bif.trip_else = 1'b1; bif.arm = 1'b1;
    timed("exit_trip", S_EXIT, TB_EXIT, 5, 7, 1'b0, 1'b0);
    clear_inputs();
    timed("exit", S_EXIT, TB_EXIT, 8, 29, 1'b0, 1'b0);
    step("armed", S_ARMED, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    timed("armed_hold", S_ARMED, 0, 1, 3, 1'b0, 1'b0);

    // Perimeter trip -> ENTRY -> ALARM, siren times out, state holds
    bif.trip_else = 1'b1;
    step("entry", S_ENTRY, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    bif.trip_else = 1'b0;
    timed("entry", S_ENTRY, TB_ENTRY, 1, 19, 1'b0, 1'b0);
    step("alarm", S_ALARM, 8'd4, 1'b1, 1'b0, 1'b0, 1'b1);
    timed("alarm", S_ALARM, TB_SIREN, 1, 9, 1'b0, 1'b0);
    bif.cmd_valid = 1'b1; bif.cmd = 4'b0111;
    timed("alarm_badcmd", S_ALARM, TB_SIREN, 10, 10, 1'b0, 1'b0);
    bif.cmd_valid = 1'b0; bif.cmd = 4'b1010;
    timed("alarm_novalid_dis", S_ALARM, TB_SIREN, 11, 11, 1'b0, 1'b0);
    bif.cmd = 4'b1100;
    timed("alarm_novalid_esc", S_ALARM, TB_SIREN, 12, 12, 1'b0, 1'b0);
    bif.cmd = 4'b0000; bif.arm = 1'b1;
    timed("alarm_arm", S_ALARM, TB_SIREN, 13, 13, 1'b0, 1'b0);
    bif.arm = 1'b0;
    timed("alarm_timeout", S_ALARM, TB_SIREN, 14, 45, 1'b0, 1'b0);

    // Escalate from expired ALARM; lock_ack stops the lock timeout
    bif.cmd_valid = 1'b1; bif.cmd = 4'b1100;
    step("escalate", S_EMERG, 8'd4, 1'b1, 1'b1, 1'b0, 1'b1);
    clear_inputs();
    timed("emerg_wait", S_EMERG, TB_SIREN, 1, 2, 1'b1, 1'b0);
    bif.lock_ack = 1'b1;
    timed("emerg_ack", S_EMERG, TB_SIREN, 3, 14, 1'b1, 1'b0);
    bif.lock_ack = 1'b0;
    timed("emerg_acked", S_EMERG, TB_SIREN, 15, 35, 1'b1, 1'b0);
    bif.cmd_valid = 1'b1; bif.cmd = 4'b1011;
    step("rearm", S_EXIT, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    bif.cmd_valid = 1'b0; bif.cmd = 4'b1010;
    timed("exit_novalid", S_EXIT, TB_EXIT, 1, 5, 1'b0, 1'b0);
    bif.cmd = 4'b0000; bif.disarm = 1'b1; bif.arm = 1'b1;
    step("disarm_pin", S_IDLE, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    clear_inputs();
    step("idle2", S_IDLE, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Both trips -> EMERG; lock_ack never comes -> lock_fault; WIFI disarm clears
    go_armed("t3");
    bif.trip_hub = 1'b1; bif.trip_else = 1'b1;
    step("emerg", S_EMERG, 8'd4, 1'b1, 1'b1, 1'b0, 1'b1);
    clear_inputs();
    timed("emerg_nolock", S_EMERG, TB_SIREN, 1, 19, 1'b1, 1'b0);
    timed("emerg_fault", S_EMERG, TB_SIREN, 20, 25, 1'b1, 1'b1);
    bif.cmd_valid = 1'b1; bif.cmd = 4'b1010;
    step("cmd_disarm", S_IDLE, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    clear_inputs();

    // trip_hub on the ENTRY expiry cycle wins; reset mid-EMERG beats rearm
    go_armed("t5");
    bif.trip_else = 1'b1;
    step("t5.entry", S_ENTRY, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    bif.trip_else = 1'b0;
    timed("t5.entry", S_ENTRY, TB_ENTRY, 1, 19, 1'b0, 1'b0);
    bif.trip_hub = 1'b1;
    step("entry_expiry_hub", S_EMERG, 8'd4, 1'b1, 1'b1, 1'b0, 1'b1);
    bif.trip_hub = 1'b0;
    timed("t5.emerg", S_EMERG, TB_SIREN, 1, 12, 1'b1, 1'b0);
    reset = 1'b0; bif.cmd_valid = 1'b1; bif.cmd = 4'b1011;
    step("rst_emerg", S_IDLE, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    clear_inputs();
    step("rst_emerg_hold", S_IDLE, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    go_armed("after_rst");

    // Escalate mid-siren reloads countdown with a second notify
    bif.trip_else = 1'b1;
    step("t6.entry", S_ENTRY, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    bif.trip_else = 1'b0;
    timed("t6.entry", S_ENTRY, TB_ENTRY, 1, 19, 1'b0, 1'b0);
    step("t6.alarm", S_ALARM, 8'd4, 1'b1, 1'b0, 1'b0, 1'b1);
    timed("t6.alarm", S_ALARM, TB_SIREN, 1, 14, 1'b0, 1'b0);
    bif.cmd_valid = 1'b1; bif.cmd = 4'b1100;
    step("esc_mid", S_EMERG, 8'd4, 1'b1, 1'b1, 1'b0, 1'b1);
    clear_inputs();
    timed("t6.emerg", S_EMERG, TB_SIREN, 1, 3, 1'b1, 1'b0);
    bif.disarm = 1'b1; bif.cmd_valid = 1'b1; bif.cmd = 4'b1011;
    step("disarm_vs_rearm", S_IDLE, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    clear_inputs();

    // Reset on the cycle that would enter EMERG suppresses the notify
    go_armed("t7");
    bif.trip_hub = 1'b1; reset = 1'b0;
    step("rst_vs_trip", S_IDLE, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1; bif.trip_hub = 1'b0;
    step("idle_end", S_IDLE, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Disarm beats a hub trip in ARMED
    go_armed("t8");
    bif.trip_hub = 1'b1; bif.disarm = 1'b1;
    step("disarm_vs_trip", S_IDLE, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    clear_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alarm_sequencer.md
# alarm_sequencer

Timed sequencer for the security system's alarm response. It converts arm/disarm requests, sensor trips and WIFI command codes into a state sequence with exit delay, entry delay and siren time limit. It drives the siren, the lock request towards the servo actuator, the WIFI notify pulse and the 2-bit LCD message code. It sits between the ultrasonic sensor outputs, the WIFI link and the actuator/LCD blocks.

## Interface
- TICK_CYCLES, 50_000_000: clk cycles per one-second tick (benches override).
- EXIT_S, 30: exit delay in ticks, legal range 1..255.
- ENTRY_S, 15: entry delay in ticks, legal range 1..255.
- SIREN_S, 180: maximum siren on-time in ticks, legal range 1..255.
- LOCK_TO_S, 2: ticks allowed for lock_ack, legal range 1..255.
- clk  in  1  system clock; all logic rises on posedge.
- reset  in  1  synchronous, active-low reset.
- arm  in  1  level; sampled each cycle.
- disarm  in  1  level; sampled each cycle.
- trip_else  in  1  perimeter trip from the ultrasonic sensor.
- trip_hub  in  1  hub trip from the ultrasonic sensor.
- cmd_valid  in  1  qualifies cmd for exactly that cycle.
- cmd  in  4  WIFI code: 1010 disarm, 1011 rearm, 1100 escalate; all other codes are ignored.
- lock_ack  in  1  servo confirms the locked position.
- siren  out  1  siren drive.
- lock_req  out  1  lock request to the servo.
- lock_fault  out  1  sticky flag: lock_ack timeout.
- notify  out  1  one-cycle WIFI notify pulse.
- msg  out  2  LCD code: 00 inactive, 01 armed, 10 alarm, 11 emergency.
- state_o  out  3  current state encoding.
- countdown  out  8  ticks remaining in the current timed phase.

## Operation
- States and state_o encoding: IDLE 0, EXIT 1, ARMED 2, ENTRY 3, ALARM 4, EMERG 5. Codes 6 and 7 return to IDLE on the next cycle.
- A "disarm request" is disarm=1, or cmd_valid=1 with cmd=1010. It takes IDLE from any state and has top priority.
- IDLE: arm=1 → EXIT.
- EXIT: sensors are ignored. When countdown expires → ARMED.
- ARMED: trip_hub → EMERG. Otherwise trip_else → ENTRY. trip_hub wins when both trips are high.
- ENTRY: trip_hub → EMERG. When countdown expires → ALARM.
- ALARM: cmd 1011 → EXIT (rearm). cmd 1100 → EMERG.
- EMERG: cmd 1011 → EXIT.
- Prescaler behaviour:
  - It counts 0..TICK_CYCLES-1 and raises an internal tick when the count equals TICK_CYCLES-1.
  - It is forced to 0 on every state change, so the first tick of each phase is a full period away.
- Countdown behaviour:
  - On entry, countdown loads EXIT_S, ENTRY_S or SIREN_S for EXIT, ENTRY, or ALARM/EMERG respectively. It loads 0 for IDLE and ARMED.
  - Each tick decrements countdown while it is nonzero.
  - Expiry is a tick with countdown==1. On expiry the state changes on the same edge that countdown reaches 0.
- Siren: siren=1 in ALARM and EMERG while countdown≠0. When countdown reaches 0, siren drops to 0 and the state holds; only the commands listed above leave it. Entering EMERG from ALARM reloads SIREN_S.
- Lock handshake:
  - lock_req=1 throughout EMERG and is cleared on exit.
  - An internal counter is loaded with LOCK_TO_S on EMERG entry and decrements on each tick while lock_ack=0.
  - If that counter reaches 0 while lock_ack=0, lock_fault is set.
  - The counter stops once lock_ack=1 is seen.
  - lock_fault stays set until the block enters IDLE.
- notify: a single one-cycle pulse on every entry into ALARM or EMERG, including ALARM→EMERG.
- msg:
  - IDLE → 00.
  - EXIT, ARMED, ENTRY → 01.
  - ALARM → 10.
  - EMERG → 11.

## Timing
- All outputs are registered and valid on the same edge as the state they reflect; there is no combinational input→output path.
- Reset values (reset=0 at a clk edge): state IDLE, siren 0, lock_req 0, lock_fault 0, notify 0, msg 00, state_o 0, countdown 0, prescaler 0.
- Reset asserted mid-sequence aborts at the next edge with these values; a pending notify is suppressed.
- Request latency: an input sampled at edge k produces the new state and outputs at edge k+1.
- A timed phase entered at edge E transitions at edge E + N·TICK_CYCLES, where N is the loaded delay.
- Simultaneous events in the same cycle:
  - reset beats everything.
  - disarm beats everything else.
  - A request beats expiry, e.g. trip_hub during the ENTRY expiry cycle → EMERG.
- cmd is ignored when cmd_valid=0. arm is ignored outside IDLE.

## Test plan
Bench parameters: TICK_CYCLES=10, EXIT_S=3, ENTRY_S=2, SIREN_S=4, LOCK_TO_S=2.
- Reset then arm pulse → EXIT with countdown=3 at the next edge. ARMED exactly 30 cycles later. siren=0 and msg=01 throughout.
- In ARMED, trip_else → ENTRY with countdown=2. ALARM 20 cycles later with a 1-cycle notify, siren=1, msg=10. siren=0 at 40 cycles; state_o stays 4.
- In ARMED, trip_hub and trip_else together → EMERG, notify pulse, lock_req=1, msg=11. With lock_ack held 0, lock_fault=1 after 20 cycles. A disarm request then gives IDLE with lock_req=0 and lock_fault=0.
- In ALARM, cmd_valid with 1100 → EMERG with countdown reloaded to 4 and a second notify. Then cmd 1011 → EXIT with countdown=3. cmd=0111 is ignored; cmd 1010 with cmd_valid=0 is ignored.
- In EXIT, trip_hub is ignored. In ENTRY, trip_hub on the expiry cycle → EMERG, not ALARM.
- reset=0 asserted in EMERG mid-countdown → all outputs take their reset values at the next edge. Release, then arm → a normal EXIT sequence.
